// File: rtl/tl_ul_pkg.sv
// TileLink-UL shared definitions: opcodes, default-width beat structs, width helpers.
package tl_ul_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int TL_SOURCE_W = 3;
  localparam int TL_ADDR_W   = 31;
  localparam int TL_DATA_W   = 64;

  // Default-width beats; blocks with other widths build their own from params.
  typedef struct packed {
    logic [2:0]               opcode;
    logic [1:0]               size;
    logic [TL_SOURCE_W-1:0]   source;
    logic [TL_ADDR_W-1:0]     address;
    logic [TL_DATA_W/8-1:0]   mask;
    logic [TL_DATA_W-1:0]     data;
  } tlA_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             size;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_DATA_W-1:0]   data;
  } tlD_t;

  // Occupancy counter width; a zero-depth queue still gets a 1-bit (tied) count.
  function automatic int cntW(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Outstanding-request counter width, never narrower than 4 bits.
  function automatic int infW(input int maxInflight);
    int w;
    w = $clog2(maxInflight + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/tl_buf_fifo.sv
// Valid/ready queue with optional flow-through (empty bypass) and pipe (enq while full+deq).
module tl_buf_fifo
  import tl_ul_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter bit FLOW  = 1'b0,
  parameter bit PIPE  = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enqValid,
  output logic                     enqReady,
  input  logic [WIDTH-1:0]         enqData,
  output logic                     deqValid,
  input  logic                     deqReady,
  output logic [WIDTH-1:0]         deqData,
  output logic [cntW(DEPTH)-1:0]   count
);

  if (DEPTH == 0) begin : gPass
    // No storage: handshake and payload wired straight through.
    assign deqValid = enqValid;
    assign enqReady = deqReady;
    assign deqData  = enqData;
    assign count    = '0;
  end else begin : gQueue
    localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CW = cntW(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr, wrPtr;
    logic [CW-1:0]    cnt;
    logic             empty, full, doWrite, doRead;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign enqReady = !full || (PIPE && deqReady);
    assign deqValid = !empty || (FLOW && enqValid);
    assign deqData  = empty ? enqData : mem[rdPtr];
    // A flow-through beat consumed the same cycle never touches storage.
    assign doWrite  = enqValid && enqReady && !(FLOW && empty && deqReady);
    assign doRead   = deqValid && deqReady && !empty;
    assign count    = cnt;

    // Pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rdPtr <= '0;
        wrPtr <= '0;
        cnt   <= '0;
      end else begin
        if (doWrite) wrPtr <= nextPtr(wrPtr);
        if (doRead)  rdPtr <= nextPtr(rdPtr);
        cnt <= cnt + CW'(doWrite) - CW'(doRead);
      end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
      if (doWrite) mem[wrPtr] <= enqData;
    end
  end

endmodule

// File: rtl/tl_ul_buffer_param.sv
// TileLink-UL A/D buffer: one queue per channel, outstanding-request limiter, status flags.
module tl_ul_buffer_param
  import tl_ul_pkg::*;
#(
  parameter int A_DEPTH      = 2,
  parameter int D_DEPTH      = 2,
  parameter bit A_FLOW       = 1'b0,
  parameter bit A_PIPE       = 1'b0,
  parameter bit D_FLOW       = 1'b0,
  parameter bit D_PIPE       = 1'b0,
  parameter int SOURCE_W     = 3,
  parameter int ADDR_W       = 31,
  parameter int DATA_W       = 64,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_a_valid,
  output logic                               in_a_ready,
  input  logic [2:0]                         in_a_opcode,
  input  logic [1:0]                         in_a_size,
  input  logic [SOURCE_W-1:0]                in_a_source,
  input  logic [ADDR_W-1:0]                  in_a_address,
  input  logic [DATA_W/8-1:0]                in_a_mask,
  input  logic [DATA_W-1:0]                  in_a_data,
  output logic                               in_d_valid,
  input  logic                               in_d_ready,
  output logic [2:0]                         in_d_opcode,
  output logic [1:0]                         in_d_size,
  output logic [SOURCE_W-1:0]                in_d_source,
  output logic [DATA_W-1:0]                  in_d_data,
  output logic                               out_a_valid,
  input  logic                               out_a_ready,
  output logic [2:0]                         out_a_opcode,
  output logic [1:0]                         out_a_size,
  output logic [SOURCE_W-1:0]                out_a_source,
  output logic [ADDR_W-1:0]                  out_a_address,
  output logic [DATA_W/8-1:0]                out_a_mask,
  output logic [DATA_W-1:0]                  out_a_data,
  input  logic                               out_d_valid,
  output logic                               out_d_ready,
  input  logic [2:0]                         out_d_opcode,
  input  logic [1:0]                         out_d_size,
  input  logic [SOURCE_W-1:0]                out_d_source,
  input  logic [DATA_W-1:0]                  out_d_data,
  output logic [cntW(A_DEPTH)-1:0]           a_count,
  output logic [cntW(D_DEPTH)-1:0]           d_count,
  output logic [infW(MAX_INFLIGHT)-1:0]      inflight,
  output logic                               idle,
  output logic                               err_unexpected_d
);

  localparam int IW = infW(MAX_INFLIGHT);

  typedef struct packed {
    logic [2:0]            opcode;
    logic [1:0]            size;
    logic [SOURCE_W-1:0]   source;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   mask;
    logic [DATA_W-1:0]     data;
  } aBeat_t;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic [DATA_W-1:0]   data;
  } dBeat_t;

  aBeat_t aIn, aOut;
  dBeat_t dIn, dOut;
  logic   limitOk, aEnqValid, aEnqReady, aFire, dFire;

  assign aIn = '{opcode: in_a_opcode, size: in_a_size, source: in_a_source,
                 address: in_a_address, mask: in_a_mask, data: in_a_data};
  assign dIn = '{opcode: out_d_opcode, size: out_d_size, source: out_d_source,
                 data: out_d_data};

  // Limiter only looks at registered inflight, so D never reaches in_a_ready combinationally.
  assign limitOk    = (MAX_INFLIGHT == 0) || (inflight < IW'(MAX_INFLIGHT));
  assign aEnqValid  = in_a_valid && limitOk;
  assign in_a_ready = aEnqReady && limitOk;
  assign aFire      = in_a_valid && in_a_ready;
  assign dFire      = in_d_valid && in_d_ready;

  tl_buf_fifo #(.DEPTH(A_DEPTH), .WIDTH($bits(aBeat_t)), .FLOW(A_FLOW), .PIPE(A_PIPE)) uAFifo (
    .clock    (clock),
    .reset    (reset),
    .enqValid (aEnqValid),
    .enqReady (aEnqReady),
    .enqData  (aIn),
    .deqValid (out_a_valid),
    .deqReady (out_a_ready),
    .deqData  (aOut),
    .count    (a_count)
  );

  tl_buf_fifo #(.DEPTH(D_DEPTH), .WIDTH($bits(dBeat_t)), .FLOW(D_FLOW), .PIPE(D_PIPE)) uDFifo (
    .clock    (clock),
    .reset    (reset),
    .enqValid (out_d_valid),
    .enqReady (out_d_ready),
    .enqData  (dIn),
    .deqValid (in_d_valid),
    .deqReady (in_d_ready),
    .deqData  (dOut),
    .count    (d_count)
  );

  assign out_a_opcode  = aOut.opcode;
  assign out_a_size    = aOut.size;
  assign out_a_source  = aOut.source;
  assign out_a_address = aOut.address;
  assign out_a_mask    = aOut.mask;
  assign out_a_data    = aOut.data;
  assign in_d_opcode   = dOut.opcode;
  assign in_d_size     = dOut.size;
  assign in_d_source   = dOut.source;
  assign in_d_data     = dOut.data;

  // Outstanding count (floor 0, ceiling all-ones) and sticky unexpected-D flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight         <= '0;
      err_unexpected_d <= 1'b0;
    end else begin
      if (aFire && !dFire && inflight != '1)
        inflight <= inflight + 1'b1;
      else if (dFire && !aFire && inflight != '0)
        inflight <= inflight - 1'b1;
      if (dFire && inflight == '0)
        err_unexpected_d <= 1'b1;
    end
  end

  assign idle = (a_count == '0) && (d_count == '0) && (inflight == '0);

endmodule

// File: tb/tb_tl_ul_buffer_param.sv
// Bench: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_tl_ul_buffer_param;
  import tl_ul_pkg::*;

  localparam int AD = 3, DD = 2, MAXI = 4;
  localparam bit AF = 1'b0, AP = 1'b1, DF = 1'b1, DP = 1'b0;
  localparam int SW = 3, AW = 31, DW = 64;
  localparam int ABW = 3 + 2 + SW + AW + DW/8 + DW;
  localparam int DBW = 3 + 2 + SW + DW;

  typedef logic [ABW-1:0] aVec;
  typedef logic [DBW-1:0] dVec;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_a_valid, in_a_ready, in_d_valid, in_d_ready;
  logic out_a_valid, out_a_ready, out_d_valid, out_d_ready;
  logic [2:0] in_a_opcode, in_d_opcode, out_a_opcode, out_d_opcode;
  logic [1:0] in_a_size, in_d_size, out_a_size, out_d_size;
  logic [SW-1:0] in_a_source, in_d_source, out_a_source, out_d_source;
  logic [AW-1:0] in_a_address, out_a_address;
  logic [DW/8-1:0] in_a_mask, out_a_mask;
  logic [DW-1:0] in_a_data, in_d_data, out_a_data, out_d_data;
  logic [1:0] a_count, d_count;
  logic [3:0] inflight;
  logic idle, err_unexpected_d;

  int nAssert = 0, nFail = 0;
  bit checkEn = 1'b0, slvAuto = 1'b0;
  aVec aQ[$];
  dVec dQ[$];
  dVec slvQ[$];
  int  mInfl = 0;
  bit  mErr = 1'b0;

  tl_ul_buffer_param #(
    .A_DEPTH(AD), .D_DEPTH(DD), .A_FLOW(AF), .A_PIPE(AP), .D_FLOW(DF), .D_PIPE(DP),
    .SOURCE_W(SW), .ADDR_W(AW), .DATA_W(DW), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_size(in_a_size), .in_a_source(in_a_source), .in_a_address(in_a_address),
    .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_data(in_d_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_size(out_a_size), .out_a_source(out_a_source), .out_a_address(out_a_address),
    .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data),
    .a_count(a_count), .d_count(d_count), .inflight(inflight), .idle(idle),
    .err_unexpected_d(err_unexpected_d)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic randA();
    int k;
    k = $urandom_range(0, 2);
    in_a_opcode  = (k == 0) ? OP_GET : (k == 1) ? OP_PUT_FULL : OP_PUT_PARTIAL;
    in_a_size    = 2'($urandom);
    in_a_source  = SW'($urandom);
    in_a_address = AW'($urandom);
    in_a_mask    = (DW/8)'($urandom);
    in_a_data    = {$urandom, $urandom};
  endtask

  // Reference model: two queues plus an outstanding counter, advanced once per cycle.
  always @(negedge clock) begin
    bit limOk, eInARdy, eOutAVld, eOutDRdy, eInDVld, aFire, aDeq, dEnq, dFire;
    aVec inA, eOutA;
    dVec outD, eInD;
    if (checkEn) begin
      if (!reset) begin
        aQ.delete(); dQ.delete(); mInfl = 0; mErr = 1'b0;
      end
      inA  = {in_a_opcode, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data};
      outD = {out_d_opcode, out_d_size, out_d_source, out_d_data};
      limOk    = (MAXI == 0) || (mInfl < MAXI);
      eInARdy  = limOk && ((aQ.size() < AD) || (AP && out_a_ready));
      eOutAVld = (aQ.size() > 0) || (AF && in_a_valid && limOk);
      eOutA    = (aQ.size() > 0) ? aQ[0] : inA;
      eOutDRdy = (dQ.size() < DD) || (DP && in_d_ready);
      eInDVld  = (dQ.size() > 0) || (DF && out_d_valid);
      eInD     = (dQ.size() > 0) ? dQ[0] : outD;

      chk("in_a_ready", in_a_ready, eInARdy);
      chk("out_a_valid", out_a_valid, eOutAVld);
      if (eOutAVld)
        chk("out_a_bits", {out_a_opcode, out_a_size, out_a_source, out_a_address,
                           out_a_mask, out_a_data}, eOutA);
      chk("out_d_ready", out_d_ready, eOutDRdy);
      chk("in_d_valid", in_d_valid, eInDVld);
      if (eInDVld)
        chk("in_d_bits", {in_d_opcode, in_d_size, in_d_source, in_d_data}, eInD);
      chk("a_count", a_count, aQ.size());
      chk("d_count", d_count, dQ.size());
      chk("inflight", inflight, mInfl);
      chk("idle", idle, (aQ.size() == 0) && (dQ.size() == 0) && (mInfl == 0));
      chk("err_unexpected_d", err_unexpected_d, mErr);

      if (reset) begin
        aFire = in_a_valid && eInARdy;
        aDeq  = eOutAVld && out_a_ready;
        dEnq  = out_d_valid && eOutDRdy;
        dFire = eInDVld && in_d_ready;
        // Push before pop so an empty flow-through beat passes straight out.
        if (aFire) aQ.push_back(inA);
        if (aDeq)  void'(aQ.pop_front());
        if (dEnq)  dQ.push_back(outD);
        if (dFire) void'(dQ.pop_front());
        if (dFire && mInfl == 0) mErr = 1'b1;
        if (aFire && !dFire) mInfl++;
        else if (dFire && !aFire && mInfl > 0) mInfl--;
      end
    end
  end

  // Slave bookkeeping: one response per A beat leaving the buffer.
  always @(negedge clock) begin
    if (reset) begin
      if (out_a_valid && out_a_ready)
        slvQ.push_back({(out_a_opcode == OP_GET) ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK,
                        out_a_size, out_a_source, $urandom, $urandom});
      if (slvAuto && out_d_valid && out_d_ready && slvQ.size() > 0)
        void'(slvQ.pop_front());
    end
  end

  task automatic drain();
    bit done;
    done = 1'b0;
    in_a_valid = 1'b0; out_a_ready = 1'b1; in_d_ready = 1'b1; out_d_valid = 1'b0;
    repeat (4) cyc();
    for (int k = 0; k < 60 && !done; k++) begin
      cyc();
      out_d_valid = (inflight != 0);
      @(negedge clock);
      done = idle;
    end
    out_d_valid = 1'b0;
    chk("drain_idle", idle, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    in_a_valid = 0; out_a_ready = 1; out_d_valid = 0; in_d_ready = 1;
    randA();
    out_d_opcode = 0; out_d_size = 0; out_d_source = 0; out_d_data = 0;
    checkEn = 1'b1;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_a_ready", in_a_ready, 1'b1);
    chk("rst_out_a_valid", out_a_valid, 1'b0);
    chk("rst_in_d_valid", in_d_valid, 1'b0);
    chk("rst_out_d_ready", out_d_ready, 1'b1);
    chk("rst_idle", idle, 1'b1);
    chk("rst_counts", {a_count, d_count, inflight}, 8'h00);
    cyc(); reset = 1'b1;
    repeat (2) cyc();

    // Single Get, slave answers after 3 cycles.
    in_a_valid = 1; in_a_opcode = OP_GET; in_a_size = 2'd3; in_a_source = 3'd5;
    in_a_address = 31'h1000_0000; in_a_mask = 8'hFF;
    @(negedge clock);
    chk("get_accept", in_a_ready, 1'b1);
    chk("get_noflow", out_a_valid, 1'b0);
    cyc(); in_a_valid = 0;
    @(negedge clock);
    chk("get_out_a_valid", out_a_valid, 1'b1);
    chk("get_out_a_addr", out_a_address, 31'h1000_0000);
    chk("get_out_a_src", out_a_source, 3'd5);
    chk("get_inflight1", inflight, 4'd1);
    repeat (3) cyc();
    out_d_valid = 1; out_d_opcode = OP_ACCESS_ACK_DATA; out_d_size = 2'd3;
    out_d_source = 3'd5; out_d_data = 64'hDEADBEEF_CAFEF00D;
    @(negedge clock);
    chk("get_d_flow_valid", in_d_valid, 1'b1);
    chk("get_d_data", in_d_data, 64'hDEADBEEF_CAFEF00D);
    chk("get_d_op_src", {in_d_opcode, in_d_source}, {OP_ACCESS_ACK_DATA, 3'd5});
    cyc(); out_d_valid = 0;
    @(negedge clock);
    chk("get_inflight0", inflight, 4'd0);
    chk("get_idle", idle, 1'b1);

    // Limiter: slave withholds D, only MAX_INFLIGHT accepted.
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(); in_a_valid = 1; randA();
      @(negedge clock);
      if (in_a_ready) acc++;
    end
    chk("lim_accepted", acc, 4);
    chk("lim_ready_low", in_a_ready, 1'b0);
    chk("lim_inflight4", inflight, 4'd4);
    cyc(); out_d_valid = 1;
    @(negedge clock);
    chk("lim_ready_same_cycle", in_a_ready, 1'b0);
    cyc(); out_d_valid = 0;
    @(negedge clock);
    chk("lim_ready_next", in_a_ready, 1'b1);
    chk("lim_inflight3", inflight, 4'd3);
    cyc(); in_a_valid = 0;
    @(negedge clock);
    chk("lim_fifth", inflight, 4'd4);
    drain();

    // Pipe: full A queue still accepts when the slave dequeues.
    out_a_ready = 0; in_a_valid = 1;
    for (int k = 0; k < 4; k++) begin
      cyc(); randA();
      @(negedge clock);
    end
    chk("pipe_full", a_count, 2'd3);
    chk("pipe_blocked", in_a_ready, 1'b0);
    cyc(); out_a_ready = 1;
    @(negedge clock);
    chk("pipe_accept_full", in_a_ready, 1'b1);
    cyc(); in_a_valid = 0;
    @(negedge clock);
    chk("pipe_count_held", a_count, 2'd3);
    chk("pipe_inflight4", inflight, 4'd4);
    drain();

    // Unexpected D with nothing outstanding.
    cyc(); out_d_valid = 1; in_d_ready = 1;
    cyc(); out_d_valid = 0;
    @(negedge clock);
    chk("err_set", err_unexpected_d, 1'b1);
    chk("err_inflight0", inflight, 4'd0);
    repeat (3) cyc();
    @(negedge clock);
    chk("err_sticky", err_unexpected_d, 1'b1);

    // Reset mid-traffic with 2 beats queued and 3 outstanding.
    out_a_ready = 0; in_a_valid = 1;
    repeat (3) begin cyc(); randA(); end
    cyc(); in_a_valid = 0; out_a_ready = 1;
    cyc(); out_a_ready = 0;
    @(negedge clock);
    chk("pre_rst_a_count", a_count, 2'd2);
    chk("pre_rst_inflight", inflight, 4'd3);
    cyc(); reset = 0;
    @(negedge clock);
    chk("mid_rst_valids", {out_a_valid, in_d_valid}, 2'b00);
    chk("mid_rst_counts", {a_count, d_count, inflight}, 8'h00);
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_err", err_unexpected_d, 1'b0);
    chk("mid_rst_readies", {in_a_ready, out_d_ready}, 2'b11);
    cyc(); reset = 1;

    // Random traffic with a well-behaved slave and one mid-run reset.
    slvQ.delete();
    slvAuto = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (i == 1500) reset = 0;
      if (i == 1501) slvQ.delete();
      if (i == 1502) reset = 1;
      in_a_valid  = ($urandom_range(0, 3) != 0);
      randA();
      out_a_ready = ($urandom_range(0, 3) != 0);
      in_d_ready  = ($urandom_range(0, 2) != 0);
      if (slvQ.size() > 0 && $urandom_range(0, 2) != 0) begin
        out_d_valid = 1;
        {out_d_opcode, out_d_size, out_d_source, out_d_data} = slvQ[0];
      end else begin
        out_d_valid = 0;
      end
    end
    slvAuto = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/tl_ul_buffer_param.md
# tl_ul_buffer_param

Parametrised TileLink-UL A/D channel buffer with independent per-channel depth and flow/pipe modes, plus an outstanding-request limiter and occupancy status. It sits between a TileLink-UL master and slave in the uncore (peripheral crossbars, MMIO paths) wherever timing must be cut or a slave must be protected from more in-flight requests than it can absorb. Every accepted A beat gets exactly one single-beat D response.

## Interface
- `A_DEPTH`, 2, A-channel entries; 0 = combinational pass-through.
- `D_DEPTH`, 2, D-channel entries; 0 = pass-through.
- `A_FLOW`, 0, 1 = empty A queue forwards an enqueue to deq in the same cycle.
- `A_PIPE`, 0, 1 = full A queue accepts an enqueue in a cycle where it dequeues.
- `D_FLOW`, 0, same as `A_FLOW` for D.
- `D_PIPE`, 0, same as `A_PIPE` for D.
- `SOURCE_W`, 3, source ID width.
- `ADDR_W`, 31, address width.
- `DATA_W`, 64, data width; mask width is DATA_W/8.
- `MAX_INFLIGHT`, 4, accepted-A-minus-returned-D limit; 0 = unlimited.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_a_valid/ready`, `in_a_opcode[3]`, `in_a_size[2]`, `in_a_source[SOURCE_W]`, `in_a_address[ADDR_W]`, `in_a_mask[DATA_W/8]`, `in_a_data[DATA_W]`: A from master (ready out, rest in).
- `in_d_valid/ready`, `in_d_opcode[3]`, `in_d_size[2]`, `in_d_source`, `in_d_data`: D to master (ready in, rest out).
- `out_a_*`: same fields as `in_a_*`, toward slave (valid/bits out, ready in).
- `out_d_*`: same fields as `in_d_*`, from slave (valid/bits in, ready out).
- `a_count`  out  $clog2(A_DEPTH+1)  A queue occupancy (width 1 when A_DEPTH=0, held 0).
- `d_count`  out  $clog2(D_DEPTH+1)  D queue occupancy (width 1 when D_DEPTH=0, held 0).
- `inflight`  out  $clog2(MAX_INFLIGHT+1) (min 4)  outstanding requests.
- `idle`  out  1  both queues empty and `inflight`==0.
- `err_unexpected_d`  out  1  sticky: D delivered to master while `inflight`==0.

## Operation
- A path: `in_a` → A queue → `out_a`. D path: `out_d` → D queue → `in_d`. Fields carried unmodified, in order.
- Accept A (`a_fire`) = `in_a_valid & in_a_ready`. Return D (`d_fire`) = `in_d_valid & in_d_ready`.
- `in_a_ready` = A-queue enq-ready AND (`MAX_INFLIGHT`==0 OR `inflight` < `MAX_INFLIGHT`). No combinational path from any D signal into `in_a_ready`.
- `inflight`: +1 on `a_fire` only, −1 on `d_fire` only, unchanged on both or neither. Saturates at 0. A `d_fire` at 0 sets `err_unexpected_d` (cleared only by reset).
- Queue full: enq-ready low unless PIPE=1 and deq-ready high that cycle. Empty: deq-valid low unless FLOW=1 and enq-valid high (data bypasses storage; no occupancy change).
- Pointers wrap modulo depth; non-power-of-two depths are legal.
- Reset (any time, including mid-transfer): queue contents discarded, pointers/counters 0, `err_unexpected_d` 0. Post-reset outputs: `out_a_valid`=0, `in_d_valid`=0, `in_a_ready`=1, `out_d_ready`=1 (depth>0; pass-through mirrors the peer ready), `a_count`=`d_count`=`inflight`=0, `idle`=1.

## Timing
- Depth>0, FLOW=0: enqueue at edge N → deq-valid from cycle N+1. Latency 1 cycle per channel, 2 round-trip added.
- FLOW=1 and empty: 0-cycle latency. Depth 0: fully combinational, valid/ready/bits wired through.
- Full throughput: depth≥2, or depth 1 with PIPE=1, sustains 1 beat/cycle.
- `a_count`, `d_count`, `inflight`, `idle` are registered-state derived, valid the cycle after the causing edge.
- Limit at `MAX_INFLIGHT`: `in_a_ready` rises the cycle after the freeing `d_fire`.

## Structure
- Package `tl_ul_pkg`: opcode constants (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1), packed A/D bit-struct typedefs built from width parameters.
- One sub-module `tl_buf_fifo` (params DEPTH, WIDTH, FLOW, PIPE; valid/ready enq/deq, count); instantiated once per channel on the packed bundle. Limiter, error flag and `idle` live in the top.

## Test plan
- Single Get addr 0x1000_0000 source 5, slave answers AccessAckData data 0xDEADBEEF_CAFEF00D after 3 cycles, defaults → `out_a_valid` at N+1, `in_d` data matches, `inflight` 1→0, `idle` back to 1.
- Back-to-back 16 PutFull, slave always ready, A_DEPTH=2, MAX_INFLIGHT=0 → 16 beats in 16 consecutive cycles on `out_a`, order preserved.
- MAX_INFLIGHT=4, slave withholds D → 4 accepted, `in_a_ready`=0 with `inflight`=4; one D returned → ready high next cycle, 5th accepted.
- A_DEPTH=1 A_PIPE=1 vs A_PIPE=0 streaming → 1 beat/cycle vs 1 beat/2 cycles; A_FLOW=1 empty → `out_a_valid` same cycle as `in_a_valid`.
- Slave D injected with no request outstanding → `err_unexpected_d`=1 sticky, `inflight` stays 0.
- Assert `reset` low with 2 beats queued and `inflight`=3 → next cycle all valids 0, counts 0, `idle`=1, error cleared.
